// File: rtl/stride_counter.sv
// rtl/stride_counter.sv - up/down counter stepping through odd, even or all values with wrap pulse
module stride_counter #(
   parameter int          WIDTH   = 8,
   parameter logic [31:0] RST_VAL = 32'd1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic [1:0]       mode_i,
   input  logic             dir_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             wrap_o
);

   localparam logic [1:0]       MODE_HOLD = 2'b11;
   localparam logic [WIDTH-1:0] RST_CNT   = RST_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             aligned;
   logic [WIDTH:0]   stride;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;

   // Stride 2 only when the current value already has the parity the mode
   // asks for; otherwise a single step realigns it.
   always_comb begin
      aligned = ~mode_i[1] & (cnt_q[0] == ~mode_i[0]);
      stride  = aligned ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
      sum     = {1'b0, cnt_q} + stride;
      diff    = {1'b0, cnt_q} - stride;
   end

   // The extra top bit of sum/diff is the carry/borrow, i.e. the wrap flag.
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (mode_i != MODE_HOLD)) begin
         if (dir_i) begin
            cnt_d  = diff[WIDTH-1:0];
            wrap_d = diff[WIDTH];
         end else begin
            cnt_d  = sum[WIDTH-1:0];
            wrap_d = sum[WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q  <= RST_CNT;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = wrap_q;

endmodule

// File: tb/tb_stride_counter.sv
// tb/tb_stride_counter.sv - directed and random checks of stride_counter against an arithmetic model
module tb_stride_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en_i;
   logic [1:0] mode_i;
   logic       dir_i;
   logic       load_i;
   logic [7:0] load_val_i;
   logic [7:0] cnt_o;
   logic       wrap_o;

   int errors = 0;
   int checks = 0;
   int m_cnt  = 0;
   int m_wrap = 0;

   stride_counter #(.WIDTH(8), .RST_VAL(32'd1)) dut (
      .clk        (clk),
      .reset      (reset),
      .en_i       (en_i),
      .mode_i     (mode_i),
      .dir_i      (dir_i),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .cnt_o      (cnt_o),
      .wrap_o     (wrap_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got_c, input logic got_w,
                      input logic [7:0] exp_c, input logic exp_w);
      checks++;
      assert (got_c === exp_c) else begin
         errors++;
         $error("FAIL %s cnt_o=%0d expected %0d", tag, got_c, exp_c);
      end
      checks++;
      assert (got_w === exp_w) else begin
         errors++;
         $error("FAIL %s wrap_o=%0b expected %0b", tag, got_w, exp_w);
      end
   endtask

   // Drive one cycle, advance the model by the sequence rules, compare after the edge.
   task automatic cyc(input string tag, input logic rst_n, input logic ld, input logic [7:0] lv,
                      input logic e, input logic [1:0] m, input logic d);
      int want_odd;
      int step;
      int nxt;
      reset = rst_n; load_i = ld; load_val_i = lv; en_i = e; mode_i = m; dir_i = d;
      @(posedge clk);
      if (!rst_n) begin
         m_cnt = 1; m_wrap = 0;
      end else if (ld) begin
         m_cnt = int'(lv); m_wrap = 0;
      end else if (!e || m == 2'b11) begin
         m_wrap = 0;
      end else begin
         want_odd = (m == 2'b00) ? 1 : 0;
         if (m == 2'b10)                  step = 1;
         else if (m_cnt % 2 == want_odd)  step = 2;
         else                             step = 1;
         nxt    = d ? m_cnt - step : m_cnt + step;
         m_wrap = (nxt < 0 || nxt > 255) ? 1 : 0;
         m_cnt  = (nxt + 256) % 256;
      end
      #1;
      chk(tag, cnt_o, wrap_o, 8'(m_cnt), m_wrap != 0);
   endtask

   initial begin
      reset = 1'b0; en_i = 1'b0; mode_i = 2'b00; dir_i = 1'b0; load_i = 1'b0; load_val_i = 8'd0;

      // Reset, then odd-up full lap back to 1
      cyc("reset0", 1'b0, 1'b1, 8'd77, 1'b1, 2'b00, 1'b0);
      cyc("reset1", 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 1'b0);
      chk("reset_val", cnt_o, wrap_o, 8'd1, 1'b0);
      for (int i = 0; i < 128; i++) cyc("odd_up", 1'b1, 1'b0, 8'd0, 1'b1, 2'b00, 1'b0);
      chk("odd_up_lap", cnt_o, wrap_o, 8'd1, 1'b1);

      // Even down from an odd load: 5,4,2,0,254
      cyc("ld5", 1'b1, 1'b1, 8'd5, 1'b0, 2'b01, 1'b1);
      for (int i = 0; i < 3; i++) cyc("even_dn", 1'b1, 1'b0, 8'd0, 1'b1, 2'b01, 1'b1);
      chk("even_dn_0", cnt_o, wrap_o, 8'd0, 1'b0);
      cyc("even_dn", 1'b1, 1'b0, 8'd0, 1'b1, 2'b01, 1'b1);
      chk("even_dn_wrap", cnt_o, wrap_o, 8'd254, 1'b1);

      // All-mode up through 255, then hold
      cyc("ld254", 1'b1, 1'b1, 8'd254, 1'b0, 2'b10, 1'b0);
      cyc("all_up", 1'b1, 1'b0, 8'd0, 1'b1, 2'b10, 1'b0);
      cyc("all_up", 1'b1, 1'b0, 8'd0, 1'b1, 2'b10, 1'b0);
      chk("all_up_wrap", cnt_o, wrap_o, 8'd0, 1'b1);
      cyc("all_up", 1'b1, 1'b0, 8'd0, 1'b1, 2'b10, 1'b0);
      cyc("en_off", 1'b1, 1'b0, 8'd0, 1'b0, 2'b10, 1'b0);
      cyc("en_off", 1'b1, 1'b0, 8'd0, 1'b0, 2'b10, 1'b0);
      chk("en_off_hold", cnt_o, wrap_o, 8'd1, 1'b0);

      // Load wins over enable and is not parity-coerced
      cyc("ld100", 1'b1, 1'b1, 8'd100, 1'b1, 2'b00, 1'b0);
      chk("ld100_raw", cnt_o, wrap_o, 8'd100, 1'b0);
      cyc("align", 1'b1, 1'b0, 8'd0, 1'b1, 2'b00, 1'b0);
      cyc("odd_up", 1'b1, 1'b0, 8'd0, 1'b1, 2'b00, 1'b0);
      chk("after_align", cnt_o, wrap_o, 8'd103, 1'b0);

      // Reset mid-sequence overrides load
      cyc("ld41", 1'b1, 1'b1, 8'd41, 1'b0, 2'b00, 1'b0);
      cyc("rst_mid", 1'b0, 1'b1, 8'd200, 1'b1, 2'b00, 1'b0);
      chk("rst_mid_val", cnt_o, wrap_o, 8'd1, 1'b0);
      cyc("post_rst", 1'b1, 1'b0, 8'd0, 1'b1, 2'b00, 1'b0);
      chk("post_rst_val", cnt_o, wrap_o, 8'd3, 1'b0);

      // Hold mode, then odd down
      cyc("ld7", 1'b1, 1'b1, 8'd7, 1'b0, 2'b11, 1'b0);
      for (int i = 0; i < 3; i++) cyc("hold", 1'b1, 1'b0, 8'd0, 1'b1, 2'b11, 1'b0);
      chk("hold_val", cnt_o, wrap_o, 8'd7, 1'b0);
      cyc("odd_dn", 1'b1, 1'b0, 8'd0, 1'b1, 2'b00, 1'b1);
      chk("odd_dn_val", cnt_o, wrap_o, 8'd5, 1'b0);

      // Alignment wraps and back-to-back wraps
      cyc("ld255", 1'b1, 1'b1, 8'd255, 1'b0, 2'b01, 1'b0);
      cyc("even_align_wrap", 1'b1, 1'b0, 8'd0, 1'b1, 2'b01, 1'b0);
      chk("even_align", cnt_o, wrap_o, 8'd0, 1'b1);
      cyc("odd_align_wrap", 1'b1, 1'b0, 8'd0, 1'b1, 2'b00, 1'b1);
      chk("odd_align", cnt_o, wrap_o, 8'd255, 1'b1);
      cyc("b2b_up", 1'b1, 1'b0, 8'd0, 1'b1, 2'b10, 1'b0);
      chk("b2b_up", cnt_o, wrap_o, 8'd0, 1'b1);
      cyc("b2b_dn", 1'b1, 1'b0, 8'd0, 1'b1, 2'b10, 1'b1);
      chk("b2b_dn", cnt_o, wrap_o, 8'd255, 1'b1);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         cyc("rand",
             ($urandom_range(0, 59) != 0),
             ($urandom_range(0, 9) == 0),
             8'($urandom),
             ($urandom_range(0, 4) != 0),
             2'($urandom),
             1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
